// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The controller side is the slave modport; the datapath drives the master side.
interface hazard_ctrl_if;
    // Decode-stage operands
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        id_valid;
    // Execute-stage producer and branch resolution
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_wen;
    logic        br_taken;
    // Handshake: mem_req is held high while the ALU_MEM access is outstanding.
    // The access completes in the cycle where mem_req and mem_ready are both 1.
    // Any cycle with mem_req=1 and mem_ready=0 is a wait cycle.
    logic        mem_req;
    logic        mem_ready;
    // Pipeline control
    logic        stall_pc;
    logic        stall_if_id;
    logic        bubble_id_ex;
    logic        flush_if_id;
    logic        hold_pipe;
    logic        err;
    logic [31:0] stall_cycles;
    // FSM visibility
    logic [1:0]  state_dbg;
    logic [1:0]  lu_cnt_dbg;

    modport master (
        output rs1, rs2, rs1_used, rs2_used, id_valid,
        output ex_rd, ex_is_load, ex_wen, br_taken,
        output mem_req, mem_ready,
        input  stall_pc, stall_if_id, bubble_id_ex, flush_if_id,
        input  hold_pipe, err, stall_cycles, state_dbg, lu_cnt_dbg
    );

    modport slave (
        input  rs1, rs2, rs1_used, rs2_used, id_valid,
        input  ex_rd, ex_is_load, ex_wen, br_taken,
        input  mem_req, mem_ready,
        output stall_pc, stall_if_id, bubble_id_ex, flush_if_id,
        output hold_pipe, err, stall_cycles, state_dbg, lu_cnt_dbg
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait
// freezes with a sticky timeout error, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam logic [1:0] LU_INIT   = 2'(LOAD_LAT - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  lu_cnt_q, lu_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic lu_hit;
    logic mem_wait;
    logic stall_pc_c, stall_if_id_c, bubble_id_ex_c, flush_if_id_c;
    logic hold_pipe_c, err_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            lu_cnt_q       <= 2'd0;
            wait_cnt_q     <= 8'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            lu_cnt_q       <= lu_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        // x0 is hardwired zero, so a load targeting it never creates a dependency.
        lu_hit = bus.id_valid & bus.ex_is_load & bus.ex_wen & (bus.ex_rd != 5'd0) &
                 ((bus.rs1_used & (bus.rs1 == bus.ex_rd)) |
                  (bus.rs2_used & (bus.rs2 == bus.ex_rd)));
        mem_wait = bus.mem_req & ~bus.mem_ready;

        state_d        = state_q;
        lu_cnt_d       = lu_cnt_q;
        wait_cnt_d     = 8'd0;
        stall_pc_c     = 1'b0;
        stall_if_id_c  = 1'b0;
        bubble_id_ex_c = 1'b0;
        flush_if_id_c  = 1'b0;
        hold_pipe_c    = 1'b0;
        err_c          = 1'b0;

        case (state_q)
            RUN, LU_STALL: begin
                if (mem_wait) begin
                    // A memory wait freezes everything, including the load-use countdown.
                    hold_pipe_c = 1'b1;
                    wait_cnt_d  = wait_cnt_q + 8'd1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ERR;
                    end
                end else if (bus.br_taken) begin
                    flush_if_id_c  = 1'b1;
                    bubble_id_ex_c = 1'b1;
                    state_d        = RUN;
                    lu_cnt_d       = 2'd0;
                end else if (state_q == RUN) begin
                    if (lu_hit) begin
                        stall_pc_c     = 1'b1;
                        stall_if_id_c  = 1'b1;
                        bubble_id_ex_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            lu_cnt_d = LU_INIT;
                            state_d  = LU_STALL;
                        end
                    end
                end else begin
                    stall_pc_c     = 1'b1;
                    stall_if_id_c  = 1'b1;
                    bubble_id_ex_c = 1'b1;
                    lu_cnt_d       = lu_cnt_q - 2'd1;
                    if (lu_cnt_q <= 2'd1) begin
                        state_d  = RUN;
                        lu_cnt_d = 2'd0;
                    end
                end
            end
            ERR: begin
                hold_pipe_c = 1'b1;
                err_c       = 1'b1;
            end
            default: begin
                state_d  = RUN;
                lu_cnt_d = 2'd0;
            end
        endcase

        stall_cycles_d = stall_cycles_q;
        if ((hold_pipe_c | stall_pc_c) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Outputs are forced low for the whole reset cycle, not just after the edge.
    assign bus.stall_pc     = stall_pc_c     & ~rst;
    assign bus.stall_if_id  = stall_if_id_c  & ~rst;
    assign bus.bubble_id_ex = bubble_id_ex_c & ~rst;
    assign bus.flush_if_id  = flush_if_id_c  & ~rst;
    assign bus.hold_pipe    = hold_pipe_c    & ~rst;
    assign bus.err          = err_c          & ~rst;
    assign bus.stall_cycles = rst ? 32'd0 : stall_cycles_q;
    assign bus.state_dbg    = rst ? 2'd0 : state_q;
    assign bus.lu_cnt_dbg   = rst ? 2'd0 : lu_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_LAT, default 1, legal range 1..3: number of cycles a load-use consumer is held in decode.
REQ-002 Parameter MEM_TIMEOUT, default 255, legal range 1..255: maximum consecutive memory-wait cycles before error.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Ports rs1 and rs2, input, 5 each: source register addresses of the instruction in decode (IF/ID).
REQ-006 Ports rs1_used, rs2_used and id_valid, input, 1 each: source operand is read; decode slot holds a real instruction.
REQ-007 Ports ex_rd, input, 5; ex_is_load and ex_wen, input, 1 each: destination, load flag and write-enable of the instruction in DC_ALU.
REQ-008 Port br_taken, input, 1: taken branch or jump resolved in DC_ALU this cycle.
REQ-009 Ports mem_req and mem_ready, input, 1 each: data-memory request pending in ALU_MEM; memory response valid.
REQ-010 Ports stall_pc and stall_if_id, output, 1 each: hold PC; hold IF/ID register.
REQ-011 Port bubble_id_ex, output, 1: load NOP into DC_ALU.
REQ-012 Port flush_if_id, output, 1: squash IF/ID contents.
REQ-013 Port hold_pipe, output, 1: freeze every pipeline register.
REQ-014 Port err, output, 1: sticky memory-timeout flag.
REQ-015 Port stall_cycles, output, 32: performance counter.

Function
REQ-016 States RUN, LU_STALL and ERR, plus lu_cnt (2 bit) and wait_cnt (8 bit); outputs are combinational from state, counters and inputs.
REQ-017 Load-use hit is id_valid & ex_is_load & ex_wen & ex_rd!=0 & ((rs1_used & rs1==ex_rd) | (rs2_used & rs2==ex_rd)); register x0 never causes a hazard.
REQ-018 Memory wait is mem_req & ~mem_ready; in RUN or LU_STALL it drives hold_pipe=1 and overrides all other outputs to 0; state and lu_cnt are frozen.
REQ-019 While waiting, wait_cnt increments each cycle; it clears in any cycle without a wait.
REQ-020 When wait_cnt==MEM_TIMEOUT-1 during a wait, the next state is ERR.
REQ-021 Flush rule: in RUN or LU_STALL with no memory wait and br_taken=1, flush_if_id=1 and bubble_id_ex=1; stall_pc=0 and stall_if_id=0.
REQ-022 After a flush the next state is RUN and lu_cnt is cleared; a flush takes priority over a load-use stall.
REQ-023 In RUN with no wait and no flush, a load-use hit asserts stall_pc, stall_if_id and bubble_id_ex for that cycle.
REQ-024 On such a hit, if LOAD_LAT>1 then lu_cnt<=LOAD_LAT-1 and the next state is LU_STALL; otherwise the state stays RUN.
REQ-025 In LU_STALL with no wait and no flush, stall_pc, stall_if_id and bubble_id_ex are asserted regardless of hit.
REQ-026 In LU_STALL, lu_cnt decrements each cycle; the state returns to RUN in the cycle after lu_cnt reaches 1.
REQ-027 In ERR, hold_pipe=1 and err=1; all other outputs are 0; ERR exits only by rst.
REQ-028 stall_cycles increments in every cycle where hold_pipe or stall_pc is 1, and saturates at 32'hFFFFFFFF.
REQ-029 With all inputs idle in RUN, every control output is 0.

Reset
REQ-030 When rst=1 at a clock edge: state<=RUN, lu_cnt<=0, wait_cnt<=0, stall_cycles<=0, err<=0.
REQ-031 rst overrides every other condition, including mid-stall, mid-wait and ERR.
REQ-032 While rst=1, all outputs are driven 0.

Verification
REQ-033 LOAD_LAT=1; ex_is_load=1, ex_wen=1, ex_rd=5; rs1=5, rs1_used=1, id_valid=1 -> one cycle of stall_pc=stall_if_id=bubble_id_ex=1, then 0; stall_cycles=1.
REQ-034 LOAD_LAT=3; same hit for 1 cycle, then EX bubble -> stall outputs high exactly 3 consecutive cycles; stall_cycles=3.
REQ-035 ex_rd=0 load hit pattern, or rs2 match with rs2_used=0 -> no stall.
REQ-036 Hit and br_taken together -> flush_if_id=1, bubble_id_ex=1, stall_pc=0; with LOAD_LAT=3, a branch in the 2nd LU_STALL cycle ends the stall next cycle.
REQ-037 mem_req=1, mem_ready=0 for 4 cycles during LU_STALL -> hold_pipe=1 for 4 cycles, lu_cnt unchanged; the stall resumes after mem_ready.
REQ-038 MEM_TIMEOUT=4; mem_ready held 0 -> err=1 and hold_pipe=1 from cycle 5 until rst; rst pulse returns all outputs to 0.
